// File: rtl/core.sv
// Shared types and helpers for the memory stage: op encoding, FSM states,
// store-buffer entry layout, exception causes and load extraction.
package core;

  localparam int LSU_XLEN = 32;

  // {store, unsigned, size[1:0]}; size 0 means no memory access.
  typedef enum logic [3:0] {
    MEM_NOP = 4'b0000,
    MEM_LB  = 4'b0001,
    MEM_LH  = 4'b0010,
    MEM_LW  = 4'b0011,
    MEM_LBU = 4'b0101,
    MEM_LHU = 4'b0110,
    MEM_SB  = 4'b1001,
    MEM_SH  = 4'b1010,
    MEM_SW  = 4'b1011
  } mem_op_t;

  localparam logic STORE_PRFX = 1'b1;

  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} mem_size_t;

  typedef enum logic [1:0] {LSU_IDLE, LSU_LD_REQ, LSU_LD_WAIT} lsu_state_t;

  typedef struct packed {
    logic [LSU_XLEN-1:0] addr;
    logic [3:0]          be;
    logic [LSU_XLEN-1:0] wdata;
  } sb_entry_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

  function automatic mem_size_t mem_size(mem_op_t op);
    return mem_size_t'(op[1:0]);
  endfunction

  // Shift the addressed lane down to bit 0, then extend per op.
  function automatic logic [LSU_XLEN-1:0] load_extend(logic [LSU_XLEN-1:0] rdata,
                                                      logic [1:0] off, mem_op_t op);
    logic [LSU_XLEN-1:0] lane;
    lane = rdata >> {off, 3'b000};
    case (op)
      MEM_LB:  return {{24{lane[7]}}, lane[7:0]};
      MEM_LH:  return {{16{lane[15]}}, lane[15:0]};
      MEM_LBU: return {24'd0, lane[7:0]};
      MEM_LHU: return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// In-order circular store buffer; head is valid whenever empty is low.
module lsu_store_buffer
  import core::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  sb_entry_t push_entry,
  input  logic      pop,
  output sb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: address/alignment check, store buffering
// with head-first drain, and a req/gnt/rvalid load path with writeback.
//
// Handshakes: an op transfers on a cycle where req_valid_i && req_ready_o.
// dmem_req_o and its payload stay stable until the cycle dmem_gnt_i is high.
module load_store_unit
  import core::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4,
  parameter int SB_CNT_W = $clog2(SB_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  mem_op_t         req_mem_op_i,
  input  logic [XLEN-1:0] req_base_i,
  input  logic [XLEN-1:0] req_imm_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            exc_valid_o,
  output logic [3:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_addr_o,
  output logic            dmem_req_o,
  input  logic            dmem_gnt_i,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            sb_empty_o
);

  lsu_state_t      state;
  logic [XLEN-1:0] ea;
  logic [1:0]      off;
  mem_size_t       size;
  logic            is_store, is_load, misaligned, accept, push, pop, sb_full;
  logic [3:0]      be;
  sb_entry_t       push_entry, head;

  logic [XLEN-1:0] ld_addr;
  logic [3:0]      ld_be;
  logic [1:0]      ld_off;
  mem_op_t         ld_op;
  logic [4:0]      ld_rd;

  assign ea         = req_base_i + req_imm_i;
  assign off        = ea[1:0];
  assign size       = mem_size(req_mem_op_i);
  assign is_store   = (req_mem_op_i[3] == STORE_PRFX) && (size != SZ_NONE);
  assign is_load    = (req_mem_op_i[3] != STORE_PRFX) && (size != SZ_NONE);
  assign misaligned = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));

  always_comb begin
    be = 4'b0000;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Readiness looks only at registered occupancy, never at same-cycle drain.
  always_comb begin
    req_ready_o = 1'b0;
    if (state == LSU_IDLE) begin
      if (is_store)     req_ready_o = !sb_full;
      else if (is_load) req_ready_o = sb_empty_o;
      else              req_ready_o = 1'b1;
    end
  end

  assign accept           = req_valid_i && req_ready_o;
  assign push             = accept && is_store && !misaligned;
  assign push_entry.addr  = {ea[XLEN-1:2], 2'b00};
  assign push_entry.be    = be;
  assign push_entry.wdata = req_wdata_i << {off, 3'b000};
  assign pop              = (state == LSU_IDLE) && !sb_empty_o && dmem_gnt_i;

  lsu_store_buffer #(
    .DEPTH(SB_DEPTH),
    .CNT_W(SB_CNT_W)
  ) u_sb (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (sb_full),
    .empty     (sb_empty_o)
  );

  // Loads own the port outside IDLE; otherwise the buffer head drains.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_be_o    = 4'b0000;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    if (state == LSU_LD_REQ) begin
      dmem_req_o  = 1'b1;
      dmem_be_o   = ld_be;
      dmem_addr_o = ld_addr;
    end else if ((state == LSU_IDLE) && !sb_empty_o) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = 1'b1;
      dmem_be_o    = head.be;
      dmem_addr_o  = head.addr;
      dmem_wdata_o = head.wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= LSU_IDLE;
      ld_addr     <= '0;
      ld_be       <= 4'b0000;
      ld_off      <= 2'b00;
      ld_op       <= MEM_NOP;
      ld_rd       <= 5'd0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= 5'd0;
      wb_data_o   <= '0;
      exc_valid_o <= 1'b0;
      exc_cause_o <= 4'd0;
      exc_addr_o  <= '0;
    end else begin
      wb_valid_o  <= 1'b0;
      exc_valid_o <= 1'b0;
      if (accept && misaligned) begin
        exc_valid_o <= 1'b1;
        exc_cause_o <= is_store ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
        exc_addr_o  <= ea;
      end
      case (state)
        LSU_IDLE: begin
          if (accept && is_load && !misaligned) begin
            state   <= LSU_LD_REQ;
            ld_addr <= {ea[XLEN-1:2], 2'b00};
            ld_be   <= be;
            ld_off  <= off;
            ld_op   <= req_mem_op_i;
            ld_rd   <= req_rd_i;
          end
        end
        LSU_LD_REQ: begin
          if (dmem_gnt_i) state <= LSU_LD_WAIT;
        end
        LSU_LD_WAIT: begin
          if (dmem_rvalid_i) begin
            state      <= LSU_IDLE;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= ld_rd;
            wb_data_o  <= load_extend(dmem_rdata_i, ld_off, ld_op);
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: store drain, lane placement, load
// extraction, misalignment exceptions, buffer-full stall and reset abandon.
module tb_load_store_unit;
  import core::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_mem_op;
  logic [31:0] req_base, req_imm, req_wdata;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        dmem_req, dmem_gnt, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        sb_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .SB_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_mem_op_i (req_mem_op),
    .req_base_i   (req_base),
    .req_imm_i    (req_imm),
    .req_wdata_i  (req_wdata),
    .req_rd_i     (req_rd),
    .wb_valid_o   (wb_valid),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .exc_valid_o  (exc_valid),
    .exc_cause_o  (exc_cause),
    .exc_addr_o   (exc_addr),
    .dmem_req_o   (dmem_req),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_we_o    (dmem_we),
    .dmem_be_o    (dmem_be),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .sb_empty_o   (sb_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input mem_op_t op, input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_mem_op = op;
    req_base   = base;
    req_imm    = imm;
    req_wdata  = wdata;
    req_rd     = rd;
  endtask

  task automatic idle_req();
    req_valid  = 1'b0;
    req_mem_op = MEM_NOP;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_exc_valid"}, {31'd0, exc_valid}, 32'd0);
    check({tag, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    check({tag, "_sb_empty"}, {31'd0, sb_empty}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_req();
    req_base = '0; req_imm = '0; req_wdata = '0; req_rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // SW 0x1000+4, granted on the first request cycle
    drive_op(MEM_SW, 32'h1000, 32'd4, 32'hDEADBEEF, 5'd0);
    #1 check("sw_ready", {31'd0, req_ready}, 32'd1);
    tick();
    idle_req();
    #1;
    check("sw_req", {31'd0, dmem_req}, 32'd1);
    check("sw_we", {31'd0, dmem_we}, 32'd1);
    check("sw_addr", dmem_addr, 32'h1004);
    check("sw_be", {28'd0, dmem_be}, 32'hF);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("sw_drained", {31'd0, sb_empty}, 32'd1);
    check("sw_req_off", {31'd0, dmem_req}, 32'd0);

    // SB to byte lane 3
    drive_op(MEM_SB, 32'h2003, 32'd0, 32'h000000A5, 5'd0);
    tick();
    idle_req();
    #1;
    check("sb_addr", dmem_addr, 32'h2000);
    check("sb_be", {28'd0, dmem_be}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'hA5000000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;

    // LH / LHU at 0x3002, rvalid two cycles after gnt
    for (int k = 0; k < 2; k++) begin
      drive_op((k == 0) ? MEM_LH : MEM_LHU, 32'h3000, 32'd2, 32'd0, 5'd5 + 5'(k));
      #1 check("lh_ready", {31'd0, req_ready}, 32'd1);
      tick();
      idle_req();
      #1;
      check("lh_req", {31'd0, dmem_req}, 32'd1);
      check("lh_we", {31'd0, dmem_we}, 32'd0);
      check("lh_addr", dmem_addr, 32'h3000);
      check("lh_be", {28'd0, dmem_be}, 32'hC);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      #1 check("lh_req_after_gnt", {31'd0, dmem_req}, 32'd0);
      tick();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h80010000;
      tick();
      dmem_rvalid = 1'b0;
      #1;
      check("lh_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("lh_wb_rd", {27'd0, wb_rd}, 32'd5 + 32'(k));
      check("lh_wb_data", wb_data, (k == 0) ? 32'hFFFF8001 : 32'h00008001);
      tick();
      check("lh_wb_pulse", {31'd0, wb_valid}, 32'd0);
    end

    // Misaligned LW then SH: exception only, no memory traffic
    drive_op(MEM_LW, 32'h4000, 32'd1, 32'd0, 5'd1);
    tick();
    idle_req();
    #1;
    check("lw_mis_exc", {31'd0, exc_valid}, 32'd1);
    check("lw_mis_cause", {28'd0, exc_cause}, 32'd4);
    check("lw_mis_addr", exc_addr, 32'h4001);
    check("lw_mis_noreq", {31'd0, dmem_req}, 32'd0);
    drive_op(MEM_SH, 32'h4003, 32'd0, 32'h1234, 5'd0);
    tick();
    idle_req();
    #1;
    check("sh_mis_exc", {31'd0, exc_valid}, 32'd1);
    check("sh_mis_cause", {28'd0, exc_cause}, 32'd6);
    check("sh_mis_addr", exc_addr, 32'h4003);
    check("sh_mis_noreq", {31'd0, dmem_req}, 32'd0);
    check("sh_mis_empty", {31'd0, sb_empty}, 32'd1);
    tick();
    check("mis_exc_pulse", {31'd0, exc_valid}, 32'd0);

    // Fill the buffer with gnt low; first store uses a negative offset
    for (int i = 0; i < 4; i++) begin
      drive_op(MEM_SW, (i == 0) ? 32'h5010 : 32'h5000, (i == 0) ? 32'hFFFFFFF0 : 32'(4 * i),
               32'hA0 + 32'(i), 5'd0);
      #1 check("fill_ready", {31'd0, req_ready}, 32'd1);
      tick();
    end
    drive_op(MEM_SW, 32'h7000, 32'd0, 32'h77, 5'd0);
    dmem_gnt = 1'b1;
    #1;
    check("full_ready", {31'd0, req_ready}, 32'd0);
    check("full_head_addr", dmem_addr, 32'h5000);
    check("full_head_data", dmem_wdata, 32'hA0);
    tick();
    drive_op(MEM_LW, 32'h6000, 32'd0, 32'd0, 5'd9);
    for (int i = 1; i < 4; i++) begin
      #1;
      check("drain_load_held", {31'd0, req_ready}, 32'd0);
      check("drain_addr", dmem_addr, 32'h5000 + 32'(4 * i));
      check("drain_data", dmem_wdata, 32'hA0 + 32'(i));
      tick();
    end
    dmem_gnt = 1'b0;
    #1;
    check("drain_empty", {31'd0, sb_empty}, 32'd1);
    check("load_after_drain_ready", {31'd0, req_ready}, 32'd1);
    tick();
    idle_req();
    #1;
    check("load_after_drain_req", {31'd0, dmem_req}, 32'd1);
    check("load_after_drain_we", {31'd0, dmem_we}, 32'd0);
    check("load_after_drain_addr", dmem_addr, 32'h6000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;

    // Reset while in LD_WAIT, late rvalid must be ignored
    rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check_reset_outputs("rst_after");
    tick();
    check("rst_no_wb", {31'd0, wb_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
